pipe_hazard_unit: RTL and testbench

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_pkg.sv | 45 ++++
 rtl/pipe_hazard_unit_if.sv | 31 +++
 rtl/pipe_mem_wait.sv | 29 ++
 rtl/pipe_hazard_unit.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the hazard/control unit: instruction
// codes, status codes, the "no register" ID and the control FSM states.
package pipe_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Stage status codes
    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    // "No register" is all-ones; users slice this to their register-ID width
    localparam logic [31:0] RNONE = '1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } hz_state_e;

    // Status that freezes the pipeline once it reaches write-back
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

    // Instructions that touch data memory while in the M stage
    function automatic logic is_mem_op(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
               (icode == I_RET)    || (icode == I_PUSHQ)  || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave):
// stage status going in, stall/bubble/halt controls coming out.
interface pipe_hazard_unit_if #(
    parameter int REG_W = 4
);
    logic [3:0]       D_icode;
    logic [REG_W-1:0] d_srcA;
    logic [REG_W-1:0] d_srcB;
    logic [3:0]       E_icode;
    logic [REG_W-1:0] E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;

    logic F_stall, D_stall, E_stall, M_stall, W_stall;
    logic D_bubble, E_bubble, M_bubble, W_bubble;
    logic halted;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, E_stall, M_stall, W_stall,
        input  D_bubble, E_bubble, M_bubble, W_bubble, halted
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, E_stall, M_stall, W_stall,
        output D_bubble, E_bubble, M_bubble, W_bubble, halted
    );
endinterface

// File: rtl/pipe_mem_wait.sv
// Multi-cycle data-memory wait: keeps a memory instruction in M for exactly
// MEM_LAT cycles. The count restarts after the last cycle so back-to-back
// memory instructions each get their full latency. freeze holds the count.
module pipe_mem_wait #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_op,
    input  logic freeze,
    output logic mem_stall
);
    localparam int             CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(MEM_LAT - 1);

    logic [CW-1:0] r_mem_cnt;

    // With MEM_LAT=1 the count never leaves 0 == LAST, so no stall is ever raised
    assign mem_stall = mem_op && (r_mem_cnt != LAST);

    // Count waited cycles while stalling; clear on the releasing cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_cnt <= '0;
        end else if (!freeze) begin
            r_mem_cnt <= mem_stall ? r_mem_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard/control unit: load-use, ret and mispredict handling,
// multi-cycle memory waits, and a freeze FSM entered on a write-back
// exception (left only through reset).
// Optional stall/bubble performance counters: define PIPE_CTRL_PERF_EN.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int REG_W   = 4,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_unit_if.slave hz
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] bubble_cycles
`endif
);
    localparam logic [REG_W-1:0] L_RNONE = RNONE[REG_W-1:0];

    // Elaboration-only range guard; no hardware
    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_mem_lat_out_of_range
    end

    hz_state_e r_state;
    logic      r_halted;

    logic w_load_use, w_ret_pend, w_mispred, w_mem_op, w_mem_stall;
    logic w_f_stall, w_d_stall, w_e_stall, w_m_stall, w_w_stall;
    logic w_d_bubble, w_e_bubble, w_m_bubble, w_w_bubble;

    assign w_load_use = ((hz.E_icode == I_MRMOVQ) || (hz.E_icode == I_POPQ)) &&
                        (hz.E_dstM != L_RNONE) &&
                        ((hz.E_dstM == hz.d_srcA) || (hz.E_dstM == hz.d_srcB));
    assign w_ret_pend = (hz.D_icode == I_RET) || (hz.E_icode == I_RET) || (hz.M_icode == I_RET);
    assign w_mispred  = (hz.E_icode == I_JXX) && !hz.e_Cnd;
    assign w_mem_op   = is_mem_op(hz.M_icode);

    pipe_mem_wait #(.MEM_LAT(MEM_LAT)) u_mem_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_op    (w_mem_op),
        .freeze    (r_halted),
        .mem_stall (w_mem_stall)
    );

    // Freeze FSM: a write-back exception halts the pipe until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (is_exc(hz.W_stat)) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end
        end else begin
            r_halted <= 1'b1;
        end
    end

    // Stage controls: halt freezes everything, memory wait holds F..M and
    // drains W, otherwise the data/control hazard rules apply
    always_comb begin
        w_f_stall  = 1'b0;
        w_d_stall  = 1'b0;
        w_e_stall  = 1'b0;
        w_m_stall  = 1'b0;
        w_w_stall  = 1'b0;
        w_d_bubble = 1'b0;
        w_e_bubble = 1'b0;
        w_m_bubble = 1'b0;
        w_w_bubble = 1'b0;
        if (r_halted) begin
            w_f_stall = 1'b1;
            w_d_stall = 1'b1;
            w_e_stall = 1'b1;
            w_m_stall = 1'b1;
            w_w_stall = 1'b1;
        end else if (w_mem_stall) begin
            w_f_stall  = 1'b1;
            w_d_stall  = 1'b1;
            w_e_stall  = 1'b1;
            w_m_stall  = 1'b1;
            w_w_bubble = 1'b1;
        end else begin
            w_f_stall  = w_load_use || w_ret_pend;
            w_d_stall  = w_load_use;
            // load_use and mispred both key off E_icode and are exclusive,
            // so D never sees stall and bubble together
            w_d_bubble = w_mispred || (w_ret_pend && !w_load_use);
            w_e_bubble = w_mispred || w_load_use;
            w_m_bubble = is_exc(hz.m_stat) || is_exc(hz.W_stat);
            w_w_stall  = is_exc(hz.W_stat);
        end
    end

    assign hz.F_stall  = w_f_stall;
    assign hz.D_stall  = w_d_stall;
    assign hz.E_stall  = w_e_stall;
    assign hz.M_stall  = w_m_stall;
    assign hz.W_stall  = w_w_stall;
    assign hz.D_bubble = w_d_bubble;
    assign hz.E_bubble = w_e_bubble;
    assign hz.M_bubble = w_m_bubble;
    assign hz.W_bubble = w_w_bubble;
    assign hz.halted   = r_halted;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_bubble_cycles;
    logic              w_any_stall, w_any_bubble;

    assign w_any_stall  = w_f_stall | w_d_stall | w_e_stall | w_m_stall | w_w_stall;
    assign w_any_bubble = w_d_bubble | w_e_bubble | w_m_bubble | w_w_bubble;

    // Saturating counters; frozen-pipe stalls are not counted as stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (!r_halted && w_any_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_any_bubble && (r_bubble_cycles != '1))
                r_bubble_cycles <= r_bubble_cycles + 1'b1;
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`else
    // PERF_W only sizes the counters; nothing to build without them
    if (PERF_W < 1) begin : g_perf_w_unused
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit (MEM_LAT=3, PERF_W=4).
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a rule-level reference model.
// Define PIPE_CTRL_PERF_EN to also exercise the performance counters.
module tb_pipe_hazard_unit;
    localparam int MEM_LAT = 3;
    localparam int REG_W   = 4;
    localparam int PERF_W  = 4;
    localparam int SAT     = (1 << PERF_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_unit_if #(.REG_W(REG_W)) hz ();

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cycles, bubble_cycles;
`endif

    pipe_hazard_unit #(.MEM_LAT(MEM_LAT), .REG_W(REG_W), .PERF_W(PERF_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: frozen flag, cycles the current M instruction
    // has already spent waiting, and saturating counts
    bit m_halted;
    int m_waited;
    int m_stall_cnt, m_bub_cnt;

    // Output vector layout: [9:5] F,D,E,M,W stall  [4:1] D,E,M,W bubble  [0] halted
    logic [9:0] last_act;

    function automatic bit exc(input int s);
        return (s == 2) || (s == 3) || (s == 4);
    endfunction

    function automatic logic [9:0] model_out();
        bit lu, rp, mp, mop, mst;
        int e, d, m;
        e   = int'(hz.E_icode);
        d   = int'(hz.D_icode);
        m   = int'(hz.M_icode);
        lu  = (e == 5 || e == 11) && (int'(hz.E_dstM) != 15) &&
              (hz.E_dstM == hz.d_srcA || hz.E_dstM == hz.d_srcB);
        rp  = (d == 9) || (e == 9) || (m == 9);
        mp  = (e == 7) && !hz.e_Cnd;
        mop = (m == 4) || (m == 5) || (m == 8) || (m == 9) || (m == 10) || (m == 11);
        mst = mop && (m_waited < MEM_LAT - 1);
        if (m_halted)
            return 10'b11111_0000_1;
        if (mst)
            return 10'b11110_0001_0;
        return {lu || rp, lu, 1'b0, 1'b0, exc(int'(hz.W_stat)),
                mp || (rp && !lu), mp || lu,
                exc(int'(hz.m_stat)) || exc(int'(hz.W_stat)), 1'b0, 1'b0};
    endfunction

    function automatic logic [9:0] dut_out();
        return {hz.F_stall, hz.D_stall, hz.E_stall, hz.M_stall, hz.W_stall,
                hz.D_bubble, hz.E_bubble, hz.M_bubble, hz.W_bubble, hz.halted};
    endfunction

    task automatic check_vec(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare DUT to model at mid-cycle and print the transaction
    task automatic compare_now(input string tag);
        logic [9:0] exp;
        exp      = model_out();
        last_act = dut_out();
        $display("[%0t] %s D=%h E=%h dstM=%h srcA=%h srcB=%h cnd=%b M=%h ms=%0d ws=%0d rst_n=%b out=%b",
                 $time, tag, hz.D_icode, hz.E_icode, hz.E_dstM, hz.d_srcA, hz.d_srcB,
                 hz.e_Cnd, hz.M_icode, hz.m_stat, hz.W_stat, rst_n, last_act);
        check_vec({tag, "_model"}, last_act, exp);
        check_int({tag, "_excl"},
                  int'((last_act[8] & last_act[4]) | (last_act[7] & last_act[3]) |
                       (last_act[6] & last_act[2]) | (last_act[5] & last_act[1])), 0);
`ifdef PIPE_CTRL_PERF_EN
        check_int({tag, "_stall_cycles"}, int'(stall_cycles), m_stall_cnt);
        check_int({tag, "_bubble_cycles"}, int'(bubble_cycles), m_bub_cnt);
`endif
    endtask

    // One clock with the inputs currently applied; entered at posedge+1
    task automatic step(input string tag);
        logic [9:0] exp;
        bit nh;
        int nw;
        #3;
        compare_now(tag);
        exp = model_out();
        nh  = m_halted || exc(int'(hz.W_stat));
        nw  = m_waited;
        if (!m_halted) nw = (exp[6] && !exp[5]) ? m_waited + 1 : 0;
        if (!m_halted && (|exp[9:5]) && m_stall_cnt < SAT) m_stall_cnt++;
        if ((|exp[4:1]) && m_bub_cnt < SAT) m_bub_cnt++;
        @(posedge clk);
        #1;
        m_halted = nh;
        m_waited = nw;
    endtask

    task automatic set_neutral();
        hz.D_icode = 4'h1; hz.d_srcA = 4'h0; hz.d_srcB = 4'h1;
        hz.E_icode = 4'h1; hz.E_dstM = 4'hF; hz.e_Cnd = 1'b1;
        hz.M_icode = 4'h1; hz.m_stat = 3'd1; hz.W_stat = 3'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_halted = 0; m_waited = 0; m_stall_cnt = 0; m_bub_cnt = 0;
        #3;
        compare_now("in_reset");
        check_int("reset_halted", int'(hz.halted), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        set_neutral();
        @(posedge clk); #1;
        do_reset();

        // Load-use on d_srcA: one-cycle hold of F/D with a bubble into E
        set_neutral(); hz.E_icode = 4'h5; hz.E_dstM = 4'h3; hz.d_srcA = 4'h3;
        step("load_use");
        check_vec("load_use_lit", last_act, 10'b11000_0100_0);
        set_neutral();
        step("load_use_after");
        check_vec("load_use_after_lit", last_act, 10'b00000_0000_0);
        // RNONE destination never creates a dependency
        hz.E_icode = 4'h5; hz.E_dstM = 4'hF; hz.d_srcB = 4'hF;
        step("rnone");
        check_vec("rnone_lit", last_act, 10'b00000_0000_0);

        // Mispredicted branch
        set_neutral(); hz.E_icode = 4'h7; hz.e_Cnd = 1'b0;
        step("mispred");
        check_vec("mispred_lit", last_act, 10'b00000_1100_0);

        // ret in decode for three cycles
        set_neutral(); hz.D_icode = 4'h9;
        for (int k = 0; k < 3; k++) begin
            step("ret");
            check_vec("ret_lit", last_act, 10'b10000_1000_0);
        end

        // Memory latency 3: two stall cycles per memory instruction, back to back
        set_neutral(); hz.M_icode = 4'h5;
        for (int k = 0; k < 3; k++) begin
            step("mem_mrmov");
            check_vec("mem_mrmov_lit", last_act, (k < 2) ? 10'b11110_0001_0 : 10'b00000_0000_0);
        end
        hz.M_icode = 4'h4;
        for (int k = 0; k < 3; k++) begin
            step("mem_rmmov");
            check_vec("mem_rmmov_lit", last_act, (k < 2) ? 10'b11110_0001_0 : 10'b00000_0000_0);
        end

        // Write-back exception, freeze, and recovery through reset
        set_neutral(); hz.W_stat = 3'd3;
        step("exc_w");
        check_vec("exc_w_lit", last_act, 10'b00001_0010_0);
        set_neutral();
        step("halted");
        check_vec("halted_lit", last_act, 10'b11111_0000_1);
        hz.E_icode = 4'h5; hz.E_dstM = 4'h3; hz.d_srcA = 4'h3; hz.M_icode = 4'h5;
        step("halted_hold");
        check_vec("halted_hold_lit", last_act, 10'b11111_0000_1);
        set_neutral();
        do_reset();
        step("post_reset");
        check_vec("post_reset_lit", last_act, 10'b00000_0000_0);

`ifdef PIPE_CTRL_PERF_EN
        // 20 load-use cycles saturate a 4-bit stall counter at 15
        do_reset();
        set_neutral(); hz.E_icode = 4'hB; hz.E_dstM = 4'h2; hz.d_srcB = 4'h2;
        for (int k = 0; k < 20; k++) step("perf_lu");
        check_int("perf_stall_sat_lit", int'(stall_cycles), 15);
        set_neutral();
`endif

        // Randomized traffic
        for (int n = 0; n < 700; n++) begin
            if (m_halted && $urandom_range(0, 4) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 120) == 0) begin
                do_reset();
            end
            hz.D_icode = 4'($urandom_range(0, 11));
            hz.d_srcA  = 4'($urandom_range(0, 15));
            hz.d_srcB  = 4'($urandom_range(0, 15));
            hz.E_icode = 4'($urandom_range(0, 11));
            hz.E_dstM  = ($urandom_range(0, 3) == 0) ? hz.d_srcA : 4'($urandom_range(0, 15));
            hz.e_Cnd   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) hz.M_icode = 4'($urandom_range(0, 11));
            hz.m_stat  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
            hz.W_stat  = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4))
                                                      : 3'($urandom_range(0, 1));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
